// File: rtl/lsp_prev_compose_pkg.sv
// Shared constants, state encoding and address helper
// for the LSP compose stage of the Qua_Lsp chain.
package lsp_prev_compose_pkg;

    localparam int M     = 10;
    localparam int MA_NP = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ELE,
        S_RD_SUM,
        S_MULT,
        S_RD_FG,
        S_MAC,
        S_WR,
        S_DONE
    } state_t;

    // Row offset into a [4][10] table, built as (k<<3)+(k<<1).
    function automatic logic [10:0] times10(input logic [2:0] k);
        logic [10:0] kw;
        kw = {8'd0, k};
        return (kw << 3) + (kw << 1);
    endfunction

endpackage

// File: rtl/lsp_prev_compose.sv
// Composes lspq[j] from lsp_ele, fg_sum, the MA history and fg
// using the shared L_mult/L_mac units and the shared scratch memory.
module lsp_prev_compose
    import lsp_prev_compose_pkg::*;
#(
    parameter logic [10:0] ELE_BASE       = 11'd0,
    parameter logic [10:0] FG_SUM_BASE0   = 11'd16,
    parameter logic [10:0] FG_SUM_BASE1   = 11'd32,
    parameter logic [10:0] FG_BASE0       = 11'd64,
    parameter logic [10:0] FG_BASE1       = 11'd128,
    parameter logic [10:0] FREQ_PREV_BASE = 11'd192,
    parameter logic [10:0] LSPQ_BASE      = 11'd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] memIn,
    output logic [10:0] memReadAddr,
    output logic [10:0] memWriteAddr,
    output logic [31:0] memOut,
    output logic        memWriteEn,
    output logic [15:0] L_multOutA,
    output logic [15:0] L_multOutB,
    input  logic [31:0] L_multIn,
    output logic [31:0] L_macOutA,
    output logic [15:0] L_macOutB,
    output logic [15:0] L_macOutC,
    input  logic [31:0] L_macIn,
    output logic        done
);

    state_t      state, state_n;
    logic [3:0]  j, j_n;
    logic [2:0]  k, k_n;
    logic [15:0] ele, ele_n;
    logic [15:0] fp, fp_n;
    logic [31:0] acc, acc_n;
    logic        mode_r, mode_r_n;

    logic [15:0] din;
    logic [10:0] j_off;
    logic [10:0] sum_base;
    logic [10:0] fg_base;
    logic        unused_mem_hi;

    assign din           = memIn[15:0];
    assign unused_mem_hi = ^memIn[31:16];
    assign j_off         = {7'd0, j};
    assign sum_base      = mode_r ? FG_SUM_BASE1 : FG_SUM_BASE0;
    assign fg_base       = mode_r ? FG_BASE1 : FG_BASE0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            j      <= '0;
            k      <= '0;
            ele    <= '0;
            fp     <= '0;
            acc    <= '0;
            mode_r <= 1'b0;
        end else begin
            state  <= state_n;
            j      <= j_n;
            k      <= k_n;
            ele    <= ele_n;
            fp     <= fp_n;
            acc    <= acc_n;
            mode_r <= mode_r_n;
        end
    end

    always_comb begin
        state_n      = state;
        j_n          = j;
        k_n          = k;
        ele_n        = ele;
        fp_n         = fp;
        acc_n        = acc;
        mode_r_n     = mode_r;
        memReadAddr  = '0;
        memWriteAddr = '0;
        memOut       = '0;
        memWriteEn   = 1'b0;
        L_multOutA   = '0;
        L_multOutB   = '0;
        L_macOutA    = '0;
        L_macOutB    = '0;
        L_macOutC    = '0;
        done         = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    mode_r_n = mode;
                    j_n      = '0;
                    k_n      = '0;
                    acc_n    = '0;
                    state_n  = S_RD_ELE;
                end
            end
            S_RD_ELE: begin
                memReadAddr = ELE_BASE + j_off;
                state_n     = S_RD_SUM;
            end
            S_RD_SUM: begin
                ele_n       = din;
                memReadAddr = sum_base + j_off;
                state_n     = S_MULT;
            end
            S_MULT: begin
                L_multOutA  = ele;
                L_multOutB  = din;
                acc_n       = L_multIn;
                memReadAddr = FREQ_PREV_BASE + times10(k) + j_off;
                state_n     = S_RD_FG;
            end
            S_RD_FG: begin
                fp_n        = din;
                memReadAddr = fg_base + times10(k) + j_off;
                state_n     = S_MAC;
            end
            S_MAC: begin
                L_macOutA = acc;
                L_macOutB = fp;
                L_macOutC = din;
                acc_n     = L_macIn;
                // Prefetch the next history tap while accumulating this one.
                if (k < 3'(MA_NP - 1)) begin
                    k_n         = k + 3'd1;
                    memReadAddr = FREQ_PREV_BASE + times10(k + 3'd1) + j_off;
                    state_n     = S_RD_FG;
                end else begin
                    k_n     = '0;
                    state_n = S_WR;
                end
            end
            S_WR: begin
                memWriteEn   = 1'b1;
                memWriteAddr = LSPQ_BASE + j_off;
                memOut       = {{16{acc[31]}}, acc[31:16]};
                if (j == 4'(M - 1)) begin
                    state_n = S_DONE;
                end else begin
                    j_n     = j + 4'd1;
                    state_n = S_RD_ELE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsp_prev_compose.sv
// Directed bench for lsp_prev_compose with a behavioural memory
// and saturating L_mult/L_mac operator models.
module tb_lsp_prev_compose;
    import lsp_prev_compose_pkg::*;

    localparam logic [10:0] ELE_B  = 11'd1000;
    localparam logic [10:0] SUM0_B = 11'd16;
    localparam logic [10:0] SUM1_B = 11'd32;
    localparam logic [10:0] FG0_B  = 11'd64;
    localparam logic [10:0] FG1_B  = 11'd128;
    localparam logic [10:0] FP_B   = 11'd192;
    localparam logic [10:0] LQ_B   = 11'd256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] memIn = '0;
    logic [10:0] memReadAddr, memWriteAddr;
    logic [31:0] memOut;
    logic        memWriteEn;
    logic [15:0] L_multOutA, L_multOutB;
    logic [31:0] L_multIn;
    logic [31:0] L_macOutA;
    logic [15:0] L_macOutB, L_macOutC;
    logic [31:0] L_macIn;
    logic        done;

    int errors = 0;
    int checks = 0;
    int bad_reads = 0;
    bit watch_b0 = 1'b0;
    int lat;

    logic [15:0] mem [0:2047];
    logic [10:0] wa[$];
    logic [31:0] wd[$];

    always #5 clk = ~clk;

    lsp_prev_compose #(
        .ELE_BASE(ELE_B), .FG_SUM_BASE0(SUM0_B), .FG_SUM_BASE1(SUM1_B),
        .FG_BASE0(FG0_B), .FG_BASE1(FG1_B),
        .FREQ_PREV_BASE(FP_B), .LSPQ_BASE(LQ_B)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .memIn(memIn), .memReadAddr(memReadAddr),
        .memWriteAddr(memWriteAddr), .memOut(memOut),
        .memWriteEn(memWriteEn),
        .L_multOutA(L_multOutA), .L_multOutB(L_multOutB),
        .L_multIn(L_multIn), .L_macOutA(L_macOutA),
        .L_macOutB(L_macOutB), .L_macOutC(L_macOutC),
        .L_macIn(L_macIn), .done(done)
    );

    function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
        longint p;
        if (a == 16'h8000 && b == 16'h8000) return 32'h7FFF_FFFF;
        p = longint'($signed(a)) * longint'($signed(b)) * 2;
        return p[31:0];
    endfunction

    function automatic logic [31:0] l_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    assign L_multIn = l_mult(L_multOutA, L_multOutB);
    assign L_macIn  = l_add(L_macOutA, l_mult(L_macOutB, L_macOutC));

    always @(posedge clk)
        memIn <= {{16{mem[memReadAddr][15]}}, mem[memReadAddr]};

    always @(posedge clk) begin
        if (memWriteEn) begin
            wa.push_back(memWriteAddr);
            wd.push_back(memOut);
        end
        if (watch_b0 &&
            ((memReadAddr >= SUM0_B && memReadAddr < SUM0_B + 11'd10) ||
             (memReadAddr >= FG0_B && memReadAddr < FG0_B + 11'd40)))
            bad_reads++;
    end

    function automatic logic [31:0] golden(input int j, input bit m);
        logic [31:0] a;
        logic [10:0] sb, gb, o;
        sb = m ? SUM1_B : SUM0_B;
        gb = m ? FG1_B : FG0_B;
        a = l_mult(mem[ELE_B + 11'(j)], mem[sb + 11'(j)]);
        for (int kk = 0; kk < 4; kk++) begin
            o = 11'(10 * kk + j);
            a = l_add(a, l_mult(mem[FP_B + o], mem[gb + o]));
        end
        return {{16{a[31]}}, a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] e, input logic [15:0] s0, input logic [15:0] s1,
                        input logic [15:0] f, input logic [15:0] g0, input logic [15:0] g1);
        for (int j = 0; j < 10; j++) begin
            mem[ELE_B + 11'(j)]  = e;
            mem[SUM0_B + 11'(j)] = s0;
            mem[SUM1_B + 11'(j)] = s1;
            for (int kk = 0; kk < 4; kk++) begin
                mem[FP_B + 11'(10 * kk + j)]  = f;
                mem[FG0_B + 11'(10 * kk + j)] = g0;
                mem[FG1_B + 11'(10 * kk + j)] = g1;
            end
        end
    endtask

    // Pulse start once; lat is the index of the done cycle,
    // counting the cycle right after the sampling edge as 1.
    task automatic run(output int l);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        l = 1;
        while (done !== 1'b1 && l < 300) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic check_writes(input string tag, input bit use_model,
                                input bit m, input logic [31:0] cexp);
        chk({tag, "_nwr"}, wa.size(), 32'd10);
        for (int j = 0; j < 10; j++) begin
            if (j < wa.size()) begin
                chk({tag, "_addr"}, {21'd0, wa[j]}, {21'd0, LQ_B + 11'(j)});
                chk({tag, "_data"}, wd[j], use_model ? golden(j, m) : cexp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wen", {31'd0, memWriteEn}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_raddr", {21'd0, memReadAddr}, 32'd0);
        chk("rst_mout", memOut, 32'd0);
        chk("rst_macA", L_macOutA, 32'd0);
        reset = 1'b1;

        fill(16'h4000, 16'h4000, 16'h1111, 16'h0000, 16'h0000, 16'h0000);
        wa.delete(); wd.delete();
        run(lat);
        chk("basic_lat", lat, 32'd121);
        @(posedge clk); #1;
        chk("basic_pulse", {31'd0, done}, 32'd0);
        check_writes("basic", 1'b0, 1'b0, 32'h0000_2000);

        fill(16'h4000, 16'h4000, 16'h1111, 16'h1000, 16'h2000, 16'h0300);
        wa.delete(); wd.delete();
        run(lat);
        chk("mac_lat", lat, 32'd121);
        check_writes("mac", 1'b0, 1'b0, 32'h0000_3000);

        fill(16'h8000, 16'h8000, 16'h1111, 16'h7FFF, 16'h7FFF, 16'h0000);
        wa.delete(); wd.delete();
        run(lat);
        check_writes("sat", 1'b0, 1'b0, 32'h0000_7FFF);

        fill(16'h8000, 16'h4000, 16'h1111, 16'h0000, 16'h0000, 16'h0000);
        wa.delete(); wd.delete();
        run(lat);
        check_writes("neg", 1'b0, 1'b0, 32'hFFFF_C000);

        // Mode 1 with distinct tables; mode flips back to 0 mid-run.
        for (int j = 0; j < 10; j++) begin
            mem[ELE_B + 11'(j)]  = 16'(32'h0800 + 32'h0111 * j);
            mem[SUM0_B + 11'(j)] = 16'h7000;
            mem[SUM1_B + 11'(j)] = 16'(32'h2000 + 32'h0100 * j);
            for (int kk = 0; kk < 4; kk++) begin
                mem[FP_B + 11'(10 * kk + j)]  = 16'(32'h0400 * (kk + 1) + j);
                mem[FG0_B + 11'(10 * kk + j)] = 16'h7FFF;
                mem[FG1_B + 11'(10 * kk + j)] = 16'(32'h1800 - 32'h0400 * kk + j);
            end
        end
        wa.delete(); wd.delete();
        bad_reads = 0;
        watch_b0 = 1'b1;
        mode = 1'b1;
        fork
            run(lat);
            begin
                repeat (40) @(posedge clk);
                #2 mode = 1'b0;
            end
        join
        watch_b0 = 1'b0;
        chk("mode1_lat", lat, 32'd121);
        chk("mode1_b0reads", bad_reads, 32'd0);
        check_writes("mode1", 1'b1, 1'b1, 32'd0);

        // Reset asserted in cycle 50 of a run.
        fill(16'h4000, 16'h4000, 16'h1111, 16'h0000, 16'h0000, 16'h0000);
        wa.delete(); wd.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (49) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mrst_wen", {31'd0, memWriteEn}, 32'd0);
        chk("mrst_raddr", {21'd0, memReadAddr}, 32'd0);
        chk("mrst_state", {29'd0, dut.state}, {29'd0, S_IDLE});
        chk("mrst_nwr", wa.size(), 32'd4);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("mrst_nwr_hold", wa.size(), 32'd4);
        @(posedge clk); #1;
        chk("mrst_idle_raddr", {21'd0, memReadAddr}, 32'd0);
        wa.delete(); wd.delete();
        run(lat);
        chk("arst_lat", lat, 32'd121);
        check_writes("arst", 1'b0, 1'b0, 32'h0000_2000);

        // Back-to-back with start held high, then a stray mid-run pulse.
        fill(16'h4000, 16'h4000, 16'h1111, 16'h1000, 16'h2000, 16'h0300);
        wa.delete(); wd.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (done !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b1_lat", lat, 32'd121);
        check_writes("b2b1", 1'b0, 1'b0, 32'h0000_3000);
        wa.delete(); wd.delete();
        @(posedge clk); #1;
        chk("b2b_idle_raddr", {21'd0, memReadAddr}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_rdele_raddr", {21'd0, memReadAddr}, {21'd0, ELE_B});
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 300) begin
            start = (lat == 30);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("b2b2_lat", lat, 32'd121);
        check_writes("b2b2", 1'b0, 1'b0, 32'h0000_3000);
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_no_third", wa.size(), 32'd10);
        chk("b2b_quiet", {31'd0, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsp_prev_compose.md
Name: lsp_prev_compose

Overview:
- Downstream neighbour of the LSP expand stages in the Qua_Lsp / Lsp_get_quant chain.
- Takes the expanded, spaced LSP residual buffer `lsp_ele[0..9]` and the MA predictor history `freq_prev[0..3][0..9]`.
- Composes the quantized LSP vector and writes it to scratch memory:
  `lspq[j] = extract_h(L_mult(lsp_ele[j], fg_sum[j]) + sum_k L_mac(freq_prev[k][j], fg[k][j]))`
- Uses the shared 11-bit-address memory and the shared L_mult/L_mac operator units, like the other Qua_Lsp FSMs.

Parameters:
- ELE_BASE, 11'd0 (overridden from paramList.v), base address of `lsp_ele[0..9]`.
- FG_SUM_BASE0 / FG_SUM_BASE1, from paramList.v, `fg_sum` table for MA mode 0 / 1.
- FG_BASE0 / FG_BASE1, from paramList.v, `fg[4][10]` table for MA mode 0 / 1, row-major.
- FREQ_PREV_BASE, from paramList.v, `freq_prev[4][10]`, row-major.
- LSPQ_BASE, from paramList.v, destination `lspq[0..9]`.
- M, 10, LSP order.
- MA_NP, 4, MA predictor taps.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request, sampled only in IDLE
- mode  in  1  MA mode select (0 → *_BASE0 tables, 1 → *_BASE1 tables); latched on start
- memIn  in  32  synchronous read data; low 16 bits used
- memReadAddr  out  11  read address
- memWriteAddr  out  11  write address
- memOut  out  32  write data, sign-extended 16-bit result
- memWriteEn  out  1  write strobe
- L_multOutA, L_multOutB  out  16  operands to shared L_mult
- L_multIn  in  32  L_mult result (combinational, same cycle)
- L_macOutA  out  32  accumulator operand to shared L_mac
- L_macOutB, L_macOutC  out  16  multiplicands to shared L_mac
- L_macIn  in  32  L_mac result (combinational, same cycle)
- done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are combinational from state and registers.
  - Every output defaults to 0 in every state except where driven.
  - During reset all outputs are 0.
- Registers:
  - `state`
  - `j` (4b)
  - `k` (3b)
  - `ele` (16b)
  - `fp` (16b)
  - `acc` (32b)
  - `modeR` (1b)
- Asynchronous active-low reset clears all registers and forces IDLE.
- Memory reads have a 1-cycle latency: an address driven in cycle N returns data on memIn in cycle N+1.
- States:
  - IDLE:
    - If start: latch mode; clear j, k, acc; go to RD_ELE.
    - start is ignored in every other state.
  - RD_ELE: `memReadAddr = ELE_BASE + j`. Next: RD_SUM.
  - RD_SUM: `ele <= memIn[15:0]`; `memReadAddr = FG_SUM_BASEx + j`. Next: MULT.
  - MULT:
    - Drive `L_multOutA = ele`, `L_multOutB = memIn[15:0]`; `acc <= L_multIn`.
    - `memReadAddr = FREQ_PREV_BASE + 10*k + j` with k = 0.
    - Next: RD_FG.
  - RD_FG: `fp <= memIn[15:0]`; `memReadAddr = FG_BASEx + 10*k + j`. Next: MAC.
  - MAC:
    - Drive `L_macOutA = acc`, `L_macOutB = fp`, `L_macOutC = memIn[15:0]`; `acc <= L_macIn`.
    - If k < 3: `k <= k + 1`; drive `memReadAddr = FREQ_PREV_BASE + 10*(k+1) + j`; next RD_FG.
    - Else: `k <= 0`; next WR.
  - WR:
    - `memWriteEn = 1`; `memWriteAddr = LSPQ_BASE + j`; `memOut = {{16{acc[31]}}, acc[31:16]}`.
    - If j == 9: next DONE. Else: `j <= j + 1`; next RD_ELE.
  - DONE: `done = 1` for one cycle. Next: IDLE.
- Arithmetic:
  - Rounding and saturation belong to the shared operators.
  - `extract_h` is bit-select `acc[31:16]`, with no rounding.
  - The `10*k` offset is formed as `(k<<3) + (k<<1)`; 11-bit address sums wrap modulo 2^11.
- Latency:
  - 12 cycles per coefficient: RD_ELE, RD_SUM, MULT, then 4×(RD_FG, MAC), then WR.
  - done is high exactly 121 cycles after the edge that samples start.
  - Exactly 10 writes, at ascending j.
- Boundary conditions:
  - start held high through DONE starts a new run on the next IDLE cycle.
  - Reset mid-run aborts immediately with no further writes. Partially written lspq is not restored.
  - mode changes mid-run have no effect.

Decomposition:
- paramList.v (shared include) holds M, MA_NP, all base addresses, and the state encoding constants.
- Operators stay external (shared L_mult/L_mac instances in the Qua_Lsp top).
- No sub-module. The address adder and the ×10 shift-add are inline.

Test Plan:
- Basic product:
  - Stimulus: `ele[j] = 0x4000`, `fg_sum[j] = 0x4000`, `freq_prev = 0`, mode 0.
  - Required: `lspq[j] = 0x2000` for all j.
  - Required: done exactly 121 cycles after start; 10 writes.
- MAC accumulation:
  - Stimulus: as basic product, plus `freq_prev[k][j] = 0x1000`, `fg[k][j] = 0x2000`.
  - Required: `acc = 0x30000000`, so `lspq[j] = 0x3000`.
- Saturation:
  - Stimulus: `ele = 0x8000`, `fg_sum = 0x8000`, `freq_prev = 0x7FFF`, `fg = 0x7FFF`.
  - Required: `lspq[j] = 0x7FFF`.
  - Negative case: `ele = 0x8000`, `fg_sum = 0x4000`, `freq_prev = 0` → `lspq[j] = 0xC000`, with memOut = 0xFFFFC000.
- Mode select:
  - Stimulus: mode = 1, with distinct values in the BASE0 and BASE1 tables.
  - Required: only BASE1 addresses appear on memReadAddr; results match the mode-1 golden model.
- Reset mid-run:
  - Stimulus: assert reset low at cycle 50.
  - Required: memWriteEn is 0 from that instant; the FSM is in IDLE; a new start produces a full correct run.
- Back-to-back runs:
  - Stimulus: start held high.
  - Required: a second run begins the cycle after DONE.
  - Required: a start pulse applied mid-run is ignored (still exactly 10 writes per run).
